// File: rtl/multicycle_ctrl_if.sv
// Datapath-facing signal bundle for the multi-cycle RISC-V control FSM.
// The controller uses the master modport; the datapath/bench uses slave.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       op;
    logic             Zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             AdrSrc;
    logic             IRWrite;
    logic             MemWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       ImmSrc;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state;

    modport master (
        input  op, Zero, mem_ready,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal,
               instret, state
    );

    modport slave (
        output op, Zero, mem_ready,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal,
               instret, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic             w_pcwrite, w_irwrite, w_memwrite, w_regwrite;
    logic             w_done, w_illegal, w_adrsrc;
    logic [1:0]       w_resultsrc, w_alusrca, w_alusrcb, w_aluop, w_immsrc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pcwrite   = 1'b0;
        w_irwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        w_done      = 1'b0;
        w_illegal   = 1'b0;
        w_adrsrc    = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_resultsrc = 2'b10;
                w_alusrcb   = 2'b10;
                w_pcwrite   = bus.mem_ready;
                w_irwrite   = bus.mem_ready;
                w_next      = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_next    = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
                w_done      = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                w_done     = bus.mem_ready;
                w_next     = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_pcwrite = bus.Zero;
                w_done    = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_immsrc = 2'b00;
        if (bus.op == OP_SW)       w_immsrc = 2'b01;
        else if (bus.op == OP_BEQ) w_immsrc = 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_instret <= '0;
        else if (w_done) r_instret <= r_instret + CNT_W'(1);
    end

    // Enables are gated by rst_n so a reset kills them without waiting for a clock.
    assign bus.PCWrite    = w_pcwrite  & rst_n;
    assign bus.IRWrite    = w_irwrite  & rst_n;
    assign bus.MemWrite   = w_memwrite & rst_n;
    assign bus.RegWrite   = w_regwrite & rst_n;
    assign bus.instr_done = w_done     & rst_n;
    assign bus.illegal    = w_illegal  & rst_n;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ALUOp      = w_aluop;
    assign bus.ImmSrc     = w_immsrc;
    assign bus.instret    = r_instret;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected cycle-by-cycle state/enable/select trace.
module tb_multicycle_ctrl;
    localparam int unsigned CW = 4;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;

    typedef struct packed {
        logic [3:0]  st;
        logic        mr;
        logic [5:0]  en;   // {PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal}
        logic [10:0] sel;  // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc}
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    cyc_t q[$];
    logic [CW-1:0] exp_cnt;
    logic [1:0]    cur_imm;
    logic [6:0]    legal_ops [5] = '{LW, SW, RT, IT, BQ};

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();
    multicycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_en();
        return {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.instr_done, bus.illegal};
    endfunction

    function automatic logic [10:0] dut_sel();
        return {bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc};
    endfunction

    task automatic add(input logic [3:0] st, input logic mr, input logic [5:0] en,
                       input logic adr, input logic [1:0] rs, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] aop);
        cyc_t c;
        c.st  = st;
        c.mr  = mr;
        c.en  = en;
        c.sel = {adr, rs, a, b, aop, cur_imm};
        q.push_back(c);
    endtask

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its expected cycles (fs/ms = stall cycles).
    task automatic gen(input logic [6:0] op, input logic z, input int fs, input int ms);
        bit ill;
        ill = !(op inside {LW, SW, RT, IT, BQ});
        cur_imm = (op == SW) ? 2'b01 : (op == BQ) ? 2'b10 : 2'b00;
        for (int i = 0; i < fs; i++) add(4'd0, 1'b0, 6'b000000, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00);
        add(4'd0, 1'b1, 6'b110000, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00);
        add(4'd1, rnd1(), {5'b00000, ill}, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00);
        if (op == LW) begin
            add(4'd2, rnd1(), 6'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00);
            for (int i = 0; i < ms; i++) add(4'd3, 1'b0, 6'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
            add(4'd3, 1'b1, 6'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
            add(4'd4, rnd1(), 6'b000110, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
        end else if (op == SW) begin
            add(4'd2, rnd1(), 6'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00);
            for (int i = 0; i < ms; i++) add(4'd5, 1'b0, 6'b001000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
            add(4'd5, 1'b1, 6'b001010, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        end else if (op == RT || op == IT) begin
            add((op == RT) ? 4'd6 : 4'd7, rnd1(), 6'b0, 1'b0, 2'b00, 2'b10,
                (op == RT) ? 2'b00 : 2'b01, 2'b10);
            add(4'd8, rnd1(), 6'b000110, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        end else if (op == BQ) begin
            add(4'd9, rnd1(), {z, 3'b000, 1'b1, 1'b0}, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run(input logic [6:0] op, input logic z, input int fs, input int ms);
        cyc_t c;
        bus.op   = op;
        bus.Zero = z;
        gen(op, z, fs, ms);
        while (q.size() > 0) begin
            c = q.pop_front();
            bus.mem_ready = c.mr;
            @(negedge clk);
            chk("state", 32'(bus.state), 32'(c.st));
            chk("enables", 32'(dut_en()), 32'(c.en));
            chk("selects", 32'(dut_sel()), 32'(c.sel));
            chk("instret", 32'(bus.instret), 32'(exp_cnt));
            @(posedge clk);
            if (c.en[1]) exp_cnt = exp_cnt + 1'b1;
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    function automatic logic [6:0] rand_illegal();
        logic [6:0] o;
        o = 7'($urandom);
        while (o inside {LW, SW, RT, IT, BQ}) o = 7'($urandom);
        return o;
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.op = LW;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b1;
        exp_cnt = '0;
        #12;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_enables", 32'(dut_en()), 32'd0);
        chk("rst_selects", 32'(dut_sel()), 32'({1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00}));
        chk("rst_instret", 32'(bus.instret), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(LW, 1'b0, 0, 0);
        run(SW, 1'b0, 0, 0);
        run(RT, 1'b0, 0, 0);
        run(IT, 1'b0, 0, 0);
        run(BQ, 1'b1, 0, 0);
        chk("seq_instret", 32'(bus.instret), 32'd5);
        run(BQ, 1'b0, 0, 0);
        chk("beq_nt_instret", 32'(bus.instret), 32'd6);
        run(LW, 1'b0, 3, 2);
        run(SW, 1'b1, 0, 4);
        run(7'b1111111, 1'b0, 0, 0);
        chk("illegal_instret", 32'(bus.instret), 32'd8);

        for (int i = 0; i < 40; i++) begin
            int k;
            logic [6:0] o;
            k = int'($urandom_range(0, 5));
            o = (k == 5) ? rand_illegal() : legal_ops[k];
            run(o, rnd1(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        do_reset();
        for (int i = 0; i < 17; i++)
            run(legal_ops[$urandom_range(0, 4)], rnd1(), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        chk("wrap_instret", 32'(bus.instret), 32'd1);

        do_reset();
        bus.op = SW;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 10 && bus.state != 4'd5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_reach_mw", 32'(bus.state), 32'd5);
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_mw_held", 32'(bus.MemWrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mw_drop", 32'(bus.MemWrite), 32'd0);
        chk("abort_state", 32'(bus.state), 32'd0);
        chk("abort_instret", 32'(bus.instret), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_enables", 32'(dut_en()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
